// File: rtl/ram_boot_loader_if.sv
// rtl/ram_boot_loader_if.sv - control, byte stream and blram port bundle for ram_boot_loader
//
// Signals (direction as seen by the loader, modport master):
//   start         in   1-cycle load request
//   s_valid       in   stream byte valid
//   s_ready       out  loader accepts the byte this cycle
//   s_data        in   stream byte
//   wrEn          out  RAM write enable
//   addr_toRAM    out  RAM word address (SIZE bits)
//   data_toRAM    out  RAM write data
//   data_fromRAM  in   RAM read data, one cycle behind its address
//   busy          out  load/verify in progress
//   done          out  image verified (sticky)
//   error         out  load failed (sticky)
//   cpu_rst       out  CPU reset hold
// The slave modport is the mirror image, for the environment side.
interface ram_boot_loader_if #(
    parameter int SIZE = 14
);
    logic            start;
    logic            s_valid;
    logic            s_ready;
    logic [7:0]      s_data;
    logic            wrEn;
    logic [SIZE-1:0] addr_toRAM;
    logic [31:0]     data_toRAM;
    logic [31:0]     data_fromRAM;
    logic            busy;
    logic            done;
    logic            error;
    logic            cpu_rst;

    modport master (
        input  start, s_valid, s_data, data_fromRAM,
        output s_ready, wrEn, addr_toRAM, data_toRAM, busy, done, error, cpu_rst
    );

    modport slave (
        output start, s_valid, s_data, data_fromRAM,
        input  s_ready, wrEn, addr_toRAM, data_toRAM, busy, done, error, cpu_rst
    );
endinterface

// File: rtl/ram_boot_loader.sv
// rtl/ram_boot_loader.sv - loads a program image from a byte stream into RAM and verifies it
//
// Ports:
//   clk   clock, all state on posedge
//   rst   asynchronous active-high reset
//   bus   ram_boot_loader_if.master: start, byte stream (s_valid/s_ready/s_data),
//         blram port (wrEn/addr_toRAM/data_toRAM/data_fromRAM), status (busy/done/error/cpu_rst)
//
// Stream: LEN (4 bytes), LEN data words (4 bytes each), CSUM (4 bytes), all MSB first.
// CSUM is the XOR of the data words; it is checked against a readback of RAM, not
// against the words as they went by, so a bad RAM path is caught too.
module ram_boot_loader #(
    parameter int SIZE      = 14,
    parameter int BASE_ADDR = 0,
    parameter int MAX_WORDS = 1024
) (
    input  logic              clk,
    input  logic              rst,
    ram_boot_loader_if.master bus
);
    localparam int              CW        = $clog2(MAX_WORDS + 1);
    localparam logic [SIZE-1:0] BASE      = SIZE'(BASE_ADDR);
    localparam logic [32:0]     BASE_WIDE = 33'(BASE_ADDR);
    localparam logic [32:0]     ADDR_SPAN = 33'd1 << SIZE;
    localparam logic [31:0]     MAX_LEN   = 32'(MAX_WORDS);

    typedef enum logic [3:0] {
        S_IDLE,
        S_LEN,
        S_DATA,
        S_WR,
        S_CSUM,
        S_RD,
        S_CHK,
        S_DONE,
        S_ERROR
    } state_t;

    state_t         state;
    logic [1:0]     bcnt;       // bytes of the current 32-bit field already taken
    logic [23:0]    shreg;      // first three bytes of the field in flight
    logic [CW-1:0]  n;          // image length in words
    logic [CW-1:0]  idx;        // write index while loading, next read index in RD
    logic [31:0]    csum;
    logic [31:0]    rb_sum;
    logic           addr_live;  // an address is on addr_toRAM this RD cycle
    logic           rd_valid;   // data_fromRAM carries the word for last cycle's address

    logic           xfer;
    logic           field_done;
    logic [31:0]    sh_next;
    logic [CW-1:0]  idx_inc;
    logic           len_bad;

    always_comb begin
        xfer       = bus.s_valid && bus.s_ready;
        field_done = xfer && (bcnt == 2'd3);
        sh_next    = {shreg, bus.s_data};
        idx_inc    = idx + CW'(1);
        // Checked in 33 bits so an image ending exactly at the top of RAM is legal
        // while anything that would wrap the address is not.
        len_bad    = (sh_next == 32'd0) || (sh_next > MAX_LEN) ||
                     (({1'b0, sh_next} + BASE_WIDE) > ADDR_SPAN);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state          <= S_IDLE;
            bcnt           <= 2'd0;
            shreg          <= 24'd0;
            n              <= '0;
            idx            <= '0;
            csum           <= 32'd0;
            rb_sum         <= 32'd0;
            addr_live      <= 1'b0;
            rd_valid       <= 1'b0;
            bus.s_ready    <= 1'b0;
            bus.wrEn       <= 1'b0;
            bus.addr_toRAM <= '0;
            bus.data_toRAM <= 32'd0;
            bus.busy       <= 1'b0;
            bus.done       <= 1'b0;
            bus.error      <= 1'b0;
            bus.cpu_rst    <= 1'b1;
        end else begin
            if (xfer) begin
                shreg <= sh_next[23:0];
                bcnt  <= bcnt + 2'd1;
            end

            case (state)
                S_IDLE, S_DONE, S_ERROR: begin
                    if (bus.start) begin
                        state       <= S_LEN;
                        bcnt        <= 2'd0;
                        idx         <= '0;
                        bus.s_ready <= 1'b1;
                        bus.busy    <= 1'b1;
                        bus.done    <= 1'b0;
                        bus.error   <= 1'b0;
                        bus.cpu_rst <= 1'b1;
                    end
                end

                S_LEN: begin
                    if (field_done) begin
                        if (len_bad) begin
                            state       <= S_ERROR;
                            bus.s_ready <= 1'b0;
                            bus.busy    <= 1'b0;
                            bus.error   <= 1'b1;
                        end else begin
                            n     <= CW'(sh_next);
                            state <= S_DATA;
                        end
                    end
                end

                S_DATA: begin
                    if (field_done) begin
                        state          <= S_WR;
                        bus.s_ready    <= 1'b0;
                        bus.wrEn       <= 1'b1;
                        bus.addr_toRAM <= BASE + SIZE'(idx);
                        bus.data_toRAM <= sh_next;
                    end
                end

                S_WR: begin
                    bus.wrEn    <= 1'b0;
                    bus.s_ready <= 1'b1;
                    idx         <= idx_inc;
                    state       <= (idx_inc == n) ? S_CSUM : S_DATA;
                end

                S_CSUM: begin
                    if (field_done) begin
                        csum           <= sh_next;
                        state          <= S_RD;
                        bus.s_ready    <= 1'b0;
                        bus.addr_toRAM <= BASE;
                        idx            <= CW'(1);
                        addr_live      <= 1'b1;
                        rd_valid       <= 1'b0;
                        rb_sum         <= 32'd0;
                    end
                end

                // One address per cycle; the XOR trails by one cycle because the
                // RAM read is registered. The final capture happens the cycle after
                // the last address, then CHK compares the settled sum.
                S_RD: begin
                    if (rd_valid) begin
                        rb_sum <= rb_sum ^ bus.data_fromRAM;
                    end
                    rd_valid <= addr_live;
                    if (idx < n) begin
                        bus.addr_toRAM <= BASE + SIZE'(idx);
                        idx            <= idx_inc;
                        addr_live      <= 1'b1;
                    end else begin
                        addr_live <= 1'b0;
                    end
                    if (rd_valid && !addr_live) begin
                        state <= S_CHK;
                    end
                end

                S_CHK: begin
                    rd_valid <= 1'b0;
                    bus.busy <= 1'b0;
                    if (rb_sum == csum) begin
                        state       <= S_DONE;
                        bus.done    <= 1'b1;
                        bus.cpu_rst <= 1'b0;
                    end else begin
                        state       <= S_ERROR;
                        bus.error   <= 1'b1;
                        bus.cpu_rst <= 1'b1;
                    end
                end

                default: state <= S_IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_ram_boot_loader.sv
// tb/tb_ram_boot_loader.sv - self-checking bench for ram_boot_loader
module tb_ram_boot_loader;
    localparam int SIZE = 14;
    localparam int BASE = 0;
    localparam int MAXW = 1024;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    ram_boot_loader_if #(.SIZE(SIZE)) bus ();

    ram_boot_loader #(.SIZE(SIZE), .BASE_ADDR(BASE), .MAX_WORDS(MAXW)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    logic [31:0] mem [0:(1<<SIZE)-1];
    always @(posedge clk) begin
        if (bus.wrEn) mem[bus.addr_toRAM] <= bus.data_toRAM;
        bus.data_fromRAM <= mem[bus.addr_toRAM];
    end

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int tests = 0;
    int fails = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h required %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Model state: the image being sent and the writes it must produce.
    logic [31:0] img[$];
    logic [31:0] exp_addr[$];
    logic [31:0] exp_data[$];
    int          wr_seen = 0;
    bit          mon_en = 1'b0;

    function automatic logic [31:0] xor_img(input int n);
        logic [31:0] s = 32'd0;
        for (int i = 0; i < n; i++) s ^= img[i];
        return s;
    endfunction

    function automatic bit pick_valid(input int mode, input int c);
        case (mode)
            0:       return 1'b1;
            1:       return (c % 2) == 0;
            2:       return $urandom_range(0, 3) != 0;
            default: return $urandom_range(0, 3) == 0;
        endcase
    endfunction

    // Per-cycle compare process: global rules plus the expected write sequence.
    always @(negedge clk) begin
        if (mon_en && !rst) begin
            chk("cpu_rst_is_not_done", bus.cpu_rst, !bus.done);
            chk("busy_excludes_status", bus.busy && (bus.done || bus.error), 0);
            chk("quiet_when_not_busy", !bus.busy && (bus.s_ready || bus.wrEn), 0);
            chk("no_ready_during_write", bus.wrEn && bus.s_ready, 0);
            if (bus.wrEn) begin
                if (wr_seen < exp_addr.size()) begin
                    chk("write_addr", bus.addr_toRAM, exp_addr[wr_seen]);
                    chk("write_data", bus.data_toRAM, exp_data[wr_seen]);
                end else begin
                    tests++;
                    fails++;
                    $display("FAIL unexpected_write: got write to %0h, required none", bus.addr_toRAM);
                end
                wr_seen++;
            end
        end
    end

    task automatic check_reset(input string tag);
        chk({tag, "_s_ready"}, bus.s_ready, 0);
        chk({tag, "_wrEn"}, bus.wrEn, 0);
        chk({tag, "_addr"}, bus.addr_toRAM, 0);
        chk({tag, "_data"}, bus.data_toRAM, 0);
        chk({tag, "_busy"}, bus.busy, 0);
        chk({tag, "_done"}, bus.done, 0);
        chk({tag, "_error"}, bus.error, 0);
        chk({tag, "_cpu_rst"}, bus.cpu_rst, 1);
    endtask

    // Called at a negedge; returns at a negedge.
    task automatic run_load(input logic [31:0] len, input logic [31:0] csum, input int mode,
                            input bit mid_start, input bit abort_mid);
        logic [7:0] q[$];
        bit         len_ok;
        bit         exp_done;
        bit         fin;
        bit         start_sent;
        bit         v;
        int         eff_n;
        int         budget;
        int         last_edge;
        int         end_edge;
        int         consumed;

        len_ok   = (len != 0) && (len <= MAXW) &&
                   (longint'(BASE) + longint'(len) <= (longint'(1) << SIZE));
        eff_n    = len_ok ? int'(len) : 0;
        exp_done = len_ok && (xor_img(eff_n) == csum);

        exp_addr.delete();
        exp_data.delete();
        for (int i = 0; i < eff_n; i++) begin
            exp_addr.push_back(32'(BASE + i));
            exp_data.push_back(img[i]);
        end
        for (int b = 3; b >= 0; b--) q.push_back(len[8*b +: 8]);
        if (len_ok) begin
            for (int i = 0; i < eff_n; i++)
                for (int b = 3; b >= 0; b--) q.push_back(img[i][8*b +: 8]);
            for (int b = 3; b >= 0; b--) q.push_back(csum[8*b +: 8]);
        end

        bus.start = 1'b1;
        @(negedge clk);
        bus.start = 1'b0;
        wr_seen = 0;
        chk("start_busy", bus.busy, 1);
        chk("start_clears_done", bus.done, 0);
        chk("start_clears_error", bus.error, 0);
        chk("start_cpu_rst", bus.cpu_rst, 1);
        chk("start_s_ready", bus.s_ready, 1);

        budget     = 8 * q.size() + 2 * eff_n + 50;
        fin        = 1'b0;
        start_sent = 1'b0;
        last_edge  = 0;
        end_edge   = 0;
        consumed   = 0;
        for (int c = 0; c < budget; c++) begin
            if (bus.done || bus.error) begin
                fin = 1'b1;
                end_edge = cyc;
                break;
            end
            if (abort_mid && consumed == 10) begin
                bus.s_valid = 1'b0;
                #1 rst = 1'b1;
                #1;
                check_reset("reset_mid_data");
                chk("partial_image_kept", mem[BASE], img[0]);
                @(negedge clk);
                rst = 1'b0;
                return;
            end
            v = (q.size() > 0) && pick_valid(mode, c);
            bus.s_valid = v;
            bus.s_data  = v ? q[0] : 8'($urandom);
            bus.start   = mid_start && !start_sent && consumed == 9;
            if (bus.start) start_sent = 1'b1;
            if (q.size() > 0 && bus.busy && !bus.wrEn)
                chk("ready_while_loading", bus.s_ready, 1);
            if (v && bus.s_ready) begin
                void'(q.pop_front());
                consumed++;
                last_edge = cyc + 1;
            end
            @(negedge clk);
        end
        bus.start   = 1'b0;
        bus.s_valid = 1'b0;

        chk("load_finished", fin, 1);
        if (fin) begin
            chk("done_flag", bus.done, exp_done);
            chk("error_flag", bus.error, !exp_done);
            chk("cpu_rst_flag", bus.cpu_rst, !exp_done);
            chk("busy_flag", bus.busy, 0);
            chk("finish_edge", end_edge, len_ok ? last_edge + eff_n + 2 : last_edge);
        end
        chk("write_count", wr_seen, eff_n);
        chk("stream_drained", q.size(), 0);
        for (int i = 0; i < eff_n; i++) chk("ram_word", mem[BASE + i], img[i]);

        bus.s_valid = 1'b1;
        bus.s_data  = 8'hA5;
        repeat (3) begin
            @(negedge clk);
            chk("no_accept_when_finished", bus.s_ready, 0);
        end
        bus.s_valid = 1'b0;
    endtask

    task automatic fill_random(input int n);
        img.delete();
        for (int i = 0; i < n; i++) img.push_back($urandom);
    endtask

    int          rn;
    int          rmode;
    logic [31:0] rcsum;

    initial begin
        bus.start   = 1'b0;
        bus.s_valid = 1'b0;
        bus.s_data  = 8'd0;
        repeat (3) @(negedge clk);
        check_reset("reset");
        rst    = 1'b0;
        mon_en = 1'b1;
        @(negedge clk);

        // Known image, steady stream.
        img = '{32'h9095c1f4, 32'h80968255, 32'h7096800a};
        chk("model_xor_pin", xor_img(3), 32'h6095c3ab);
        run_load(3, 32'h6095c3ab, 0, 1'b0, 1'b0);
        chk("pin_ram0", mem[0], 32'h9095c1f4);
        chk("pin_ram2", mem[2], 32'h7096800a);
        chk("pin_writes", wr_seen, 3);
        chk("pin_done", bus.done, 1);

        // Wrong checksum.
        run_load(3, 32'h00000000, 0, 1'b0, 1'b0);
        chk("pin_bad_csum_error", bus.error, 1);
        chk("pin_bad_csum_done", bus.done, 0);

        // Illegal lengths.
        run_load(0, 32'h0, 0, 1'b0, 1'b0);
        chk("pin_len0_error", bus.error, 1);
        run_load(1025, 32'h0, 0, 1'b0, 1'b0);
        chk("pin_len1025_error", bus.error, 1);

        // Toggling valid.
        run_load(3, 32'h6095c3ab, 1, 1'b0, 1'b0);
        chk("pin_toggle_done", bus.done, 1);

        // Reset in the middle of the second word, then a clean reload.
        fill_random(3);
        run_load(3, xor_img(3), 0, 1'b0, 1'b1);
        img = '{32'h9095c1f4, 32'h80968255, 32'h7096800a};
        run_load(3, 32'h6095c3ab, 0, 1'b0, 1'b0);
        chk("pin_after_reset_done", bus.done, 1);

        // start while loading is ignored; then a new load from DONE.
        run_load(3, 32'h6095c3ab, 2, 1'b1, 1'b0);
        fill_random(5);
        run_load(5, xor_img(5), 3, 1'b0, 1'b0);

        // Randomized images, stream patterns and checksum faults.
        for (int t = 0; t < 8; t++) begin
            rn = $urandom_range(1, 24);
            fill_random(rn);
            rcsum = xor_img(rn);
            if ($urandom_range(0, 3) == 0) rcsum ^= (32'd1 << $urandom_range(0, 31));
            rmode = $urandom_range(0, 3);
            run_load(32'(rn), rcsum, rmode, 1'b0, 1'b0);
        end

        // Largest legal image.
        fill_random(MAXW);
        run_load(MAXW, xor_img(MAXW), 0, 1'b0, 1'b0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
